// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared constants and byte-merge helper for the otter TCM
package otter_mem_pkg;

    // Register offsets inside the 16-byte MMIO window
    localparam logic [3:0] MMIO_SET  = 4'h0;
    localparam logic [3:0] MMIO_CLR  = 4'h4;
    localparam logic [3:0] MMIO_PEND = 4'h8;
    localparam logic [3:0] MMIO_EXIT = 4'hC;

    // Replace each byte of old_word whose strobe bit is set with the matching byte of new_word
    function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/otter_tcm_sim_rd_pipe.sv
// rtl/otter_tcm_sim_rd_pipe.sv - valid+data delay line that holds data across idle cycles
module rd_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = clk ^ rst;
            assign dn_valid    = up_valid;
            assign dn_data     = up_data;
        end else begin : g_dly
            logic [DEPTH-1:0] v;
            logic [WIDTH-1:0] d [DEPTH];

            // Shift valid every cycle; a data stage only loads when a valid word enters it
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v <= '0;
                    for (int i = 0; i < DEPTH; i++) d[i] <= '0;
                end else begin
                    v[0] <= up_valid;
                    if (up_valid) d[0] <= up_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        v[i] <= v[i-1];
                        if (v[i-1]) d[i] <= d[i-1];
                    end
                end
            end

            assign dn_valid = v[DEPTH-1];
            assign dn_data  = d[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/otter_tcm_sim.sv
// rtl/otter_tcm_sim.sv - dual-port TCM with interrupt and sim-exit MMIO for otter_mcu benches
module otter_tcm_sim
    import otter_mem_pkg::*;
#(
    parameter int          MEM_EXP     = 16,
    parameter int          RD_LATENCY  = 1,
    parameter int          WRITE_FIRST = 0,
    parameter logic [31:0] MMIO_BASE   = 32'h1100_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_r_data,
    output logic        imem_r_valid,
    input  logic        dmem_r_en,
    input  logic        dmem_w_en,
    input  logic [3:0]  dmem_w_strb,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_w_data,
    output logic [31:0] dmem_r_data,
    output logic        dmem_r_valid,
    input  logic [31:0] ext_intr,
    output logic [31:0] intrpt,
    output logic        sim_done,
    output logic [31:0] sim_code
);

    localparam int WORDS = 1 << (MEM_EXP - 2);

    logic [31:0] mem [WORDS];

    logic [MEM_EXP-3:0] d_idx, i_idx;
    logic               d_mmio, i_mmio, mem_we, i_hit, exit_we;
    logic [3:0]         d_off;
    logic [31:0]        d_old, d_merged, w_mask, set_mask, clr_mask;
    logic [31:0]        d_rd_word, i_rd_word;
    logic [31:0]        pending;
    logic               d1_valid, i1_valid;
    logic [31:0]        d1_data, i1_data;
    logic               unused_imem;

    assign unused_imem = ^imem_addr[1:0];

    assign d_idx    = dmem_addr[MEM_EXP-1:2];
    assign i_idx    = imem_addr[MEM_EXP-1:2];
    assign d_off    = dmem_addr[3:0];
    assign d_mmio   = (dmem_addr[31:4] == MMIO_BASE[31:4]);
    assign i_mmio   = (imem_addr[31:4] == MMIO_BASE[31:4]);
    assign mem_we   = dmem_w_en && !d_mmio;
    assign i_hit    = mem_we && (i_idx == d_idx);
    assign d_old    = mem[d_idx];
    assign d_merged = strb_merge(d_old, dmem_w_data, dmem_w_strb);
    assign w_mask   = strb_merge(32'h0, dmem_w_data, dmem_w_strb);
    assign set_mask = (dmem_w_en && d_mmio && d_off == MMIO_SET) ? w_mask : 32'h0;
    assign clr_mask = (dmem_w_en && d_mmio && d_off == MMIO_CLR) ? w_mask : 32'h0;
    assign exit_we  = dmem_w_en && d_mmio && (d_off == MMIO_EXIT);
    assign intrpt   = pending;

    // Byte-lane write into the array; contents survive reset so preloads are kept
    always_ff @(posedge clk) begin
        if (mem_we) mem[d_idx] <= d_merged;
    end

    // Data-port read source: MMIO register, or array word with optional write forwarding
    always_comb begin
        d_rd_word = 32'h0;
        if (d_mmio) begin
            case (d_off)
                MMIO_PEND: d_rd_word = pending;
                MMIO_EXIT: d_rd_word = sim_code;
                default:   d_rd_word = 32'h0;
            endcase
        end else if ((WRITE_FIRST != 0) && mem_we) begin
            d_rd_word = d_merged;
        end else begin
            d_rd_word = d_old;
        end
    end

    // Fetch source: MMIO space reads as zero, same-word data writes forward when write-first
    always_comb begin
        i_rd_word = mem[i_idx];
        if (i_mmio)                          i_rd_word = 32'h0;
        else if ((WRITE_FIRST != 0) && i_hit) i_rd_word = d_merged;
    end

    // First read stage for both ports; data register holds when no data read is requested
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d1_valid <= 1'b0;
            d1_data  <= 32'h0;
            i1_valid <= 1'b0;
            i1_data  <= 32'h0;
        end else begin
            d1_valid <= dmem_r_en;
            if (dmem_r_en) d1_data <= d_rd_word;
            i1_valid <= 1'b1;
            i1_data  <= i_rd_word;
        end
    end

    // Pending vector and exit registers; a live ext_intr bit overrides a same-cycle CLR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= 32'h0;
            sim_done <= 1'b0;
            sim_code <= 32'h0;
        end else begin
            pending <= (pending | set_mask | ext_intr) & ~(clr_mask & ~ext_intr);
            if (exit_we) begin
                sim_code <= strb_merge(sim_code, dmem_w_data, dmem_w_strb);
                sim_done <= 1'b1;
            end
        end
    end

    rd_pipe #(.WIDTH(32), .DEPTH(RD_LATENCY - 1)) u_dpipe (
        .clk      (clk),
        .rst      (rst),
        .up_valid (d1_valid),
        .up_data  (d1_data),
        .dn_valid (dmem_r_valid),
        .dn_data  (dmem_r_data)
    );

    rd_pipe #(.WIDTH(32), .DEPTH(RD_LATENCY - 1)) u_ipipe (
        .clk      (clk),
        .rst      (rst),
        .up_valid (i1_valid),
        .up_data  (i1_data),
        .dn_valid (imem_r_valid),
        .dn_data  (imem_r_data)
    );

endmodule

// File: tb/tb_otter_tcm_sim.sv
// tb/tb_otter_tcm_sim.sv - self-checking bench for otter_tcm_sim at several latencies and policies
module tb_otter_tcm_sim;

    localparam logic [31:0] MB = 32'h1100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_w_data = '0, ext_intr = '0;
    logic        dmem_r_en = 1'b0, dmem_w_en = 1'b0;
    logic [3:0]  dmem_w_strb = '0;

    logic [2:0][31:0] i_data, d_data, irq, code;
    logic [2:0]       i_valid, d_valid, done;

    int lat [3] = '{1, 3, 4};
    int wf  [3] = '{0, 1, 0};

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [int];
    logic [31:0] pool [8];

    always #5 clk = ~clk;

    otter_tcm_sim #(.RD_LATENCY(1), .WRITE_FIRST(0)) u0 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_r_data(i_data[0]), .imem_r_valid(i_valid[0]),
        .dmem_r_en(dmem_r_en), .dmem_w_en(dmem_w_en), .dmem_w_strb(dmem_w_strb), .dmem_addr(dmem_addr),
        .dmem_w_data(dmem_w_data), .dmem_r_data(d_data[0]), .dmem_r_valid(d_valid[0]),
        .ext_intr(ext_intr), .intrpt(irq[0]), .sim_done(done[0]), .sim_code(code[0]));

    otter_tcm_sim #(.RD_LATENCY(3), .WRITE_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_r_data(i_data[1]), .imem_r_valid(i_valid[1]),
        .dmem_r_en(dmem_r_en), .dmem_w_en(dmem_w_en), .dmem_w_strb(dmem_w_strb), .dmem_addr(dmem_addr),
        .dmem_w_data(dmem_w_data), .dmem_r_data(d_data[1]), .dmem_r_valid(d_valid[1]),
        .ext_intr(ext_intr), .intrpt(irq[1]), .sim_done(done[1]), .sim_code(code[1]));

    otter_tcm_sim #(.RD_LATENCY(4), .WRITE_FIRST(0)) u2 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_r_data(i_data[2]), .imem_r_valid(i_valid[2]),
        .dmem_r_en(dmem_r_en), .dmem_w_en(dmem_w_en), .dmem_w_strb(dmem_w_strb), .dmem_addr(dmem_addr),
        .dmem_w_data(dmem_w_data), .dmem_r_data(d_data[2]), .dmem_r_valid(d_valid[2]),
        .ext_intr(ext_intr), .intrpt(irq[2]), .sim_done(done[2]), .sim_code(code[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a % 32'h0001_0000) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic is_mmio(input logic [31:0] a);
        return a[31:4] == MB[31:4];
    endfunction

    function automatic logic [31:0] mget(input logic [31:0] a);
        if (mdl.exists(widx(a))) return mdl[widx(a)];
        return 32'h0;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dmem_addr = a; dmem_w_data = d; dmem_w_strb = s;
        dmem_w_en = 1'b1; dmem_r_en = 1'b0;
        tick();
        dmem_w_en = 1'b0;
        if (!is_mmio(a)) mdl[widx(a)] = merge(mget(a), d, s);
    endtask

    // Single read (optionally with a same-cycle write); e0/e1 are results for old-first/write-first
    task automatic rd(input logic [31:0] a, input logic wen, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] e0, input logic [31:0] e1);
        logic [31:0] e;
        dmem_addr = a; imem_addr = a; dmem_w_data = d; dmem_w_strb = s;
        dmem_r_en = 1'b1; dmem_w_en = wen;
        for (int k = 1; k <= 4; k++) begin
            tick();
            dmem_r_en = 1'b0; dmem_w_en = 1'b0;
            for (int i = 0; i < 3; i++) begin
                e = (wf[i] != 0) ? e1 : e0;
                check($sformatf("dvalid u%0d a%h k%0d", i, a, k), 32'(d_valid[i]), 32'(k == lat[i]));
                if (k >= lat[i]) check($sformatf("ddata u%0d a%h k%0d", i, a, k), d_data[i], e);
                if (k == lat[i]) begin
                    check($sformatf("idata u%0d a%h", i, a), i_data[i], is_mmio(a) ? 32'h0 : e);
                    check($sformatf("ivalid u%0d", i), 32'(i_valid[i]), 32'h1);
                end
            end
        end
        if (wen && !is_mmio(a)) mdl[widx(a)] = merge(mget(a), d, s);
    endtask

    task automatic check_irq(input string tag, input logic [31:0] e);
        for (int i = 0; i < 3; i++) check($sformatf("%s u%0d", tag, i), irq[i], e);
    endtask

    initial begin
        logic [31:0] a, d, old;
        logic [3:0]  s;
        int          op;

        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst dvalid u%0d", i), 32'(d_valid[i]), 32'h0);
            check($sformatf("rst ivalid u%0d", i), 32'(i_valid[i]), 32'h0);
            check($sformatf("rst ddata u%0d", i), d_data[i], 32'h0);
            check($sformatf("rst idata u%0d", i), i_data[i], 32'h0);
            check($sformatf("rst intrpt u%0d", i), irq[i], 32'h0);
            check($sformatf("rst done u%0d", i), 32'(done[i]), 32'h0);
            check($sformatf("rst code u%0d", i), code[i], 32'h0);
        end
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            for (int i = 0; i < 3; i++)
                check($sformatf("ivalid rise u%0d k%0d", i, k), 32'(i_valid[i]), 32'(k >= lat[i]));
        end

        wr(32'h40, 32'hAABB_CCDD, 4'hF);
        wr(32'h40, 32'h1122_3344, 4'b0101);
        rd(32'h40, 1'b0, 32'h0, 4'h0, 32'hAA22_CC44, 32'hAA22_CC44);

        wr(32'h80, 32'h0, 4'hF);
        rd(32'h80, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'hDEAD_BEEF);
        wr(32'h80, 32'h1234_5678, 4'h0);
        rd(32'h80, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        wr(MB + 32'h0, 32'h5, 4'hF);
        check_irq("irq set", 32'h5);
        ext_intr = 32'h1;
        wr(MB + 32'h4, 32'h1, 4'hF);
        check_irq("irq clr vs ext", 32'h5);
        ext_intr = 32'h0;
        wr(MB + 32'h4, 32'h1, 4'hF);
        check_irq("irq clr", 32'h4);
        rd(MB + 32'h8, 1'b0, 32'h0, 4'h0, 32'h4, 32'h4);
        wr(MB + 32'h0, 32'hFFFF_0000, 4'b0100);
        check_irq("irq set masked", 32'h00FF_0004);
        ext_intr = 32'h8000_0000;
        tick();
        ext_intr = 32'h0;
        tick();
        check_irq("irq ext sticky", 32'h80FF_0004);
        wr(MB + 32'h8, 32'hFFFF_FFFF, 4'hF);
        check_irq("irq pend wr ignored", 32'h80FF_0004);
        wr(MB + 32'h4, 32'hFFFF_FFFF, 4'hF);
        check_irq("irq clr all", 32'h0);
        rd(MB + 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        rd(MB + 32'h4, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);

        for (int j = 0; j < 8; j++) begin
            pool[j] = 32'h200 + 32'(4 * j);
            wr(pool[j], $urandom, 4'hF);
        end
        for (int n = 0; n < 60; n++) begin
            a   = pool[$urandom_range(0, 7)] + (32'($urandom_range(0, 3)) << 16);
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            op  = int'($urandom_range(0, 2));
            old = mget(a);
            if (op == 0)      wr(a, d, s);
            else if (op == 1) rd(a, 1'b0, 32'h0, 4'h0, old, old);
            else              rd(a, 1'b1, d, s, old, merge(old, d, s));
        end

        for (int i = 0; i < 3; i++) check($sformatf("done early u%0d", i), 32'(done[i]), 32'h0);
        wr(MB + 32'hC, 32'h1, 4'hF);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("done u%0d r%0d", i, r), 32'(done[i]), 32'h1);
                check($sformatf("code u%0d r%0d", i, r), code[i], 32'h1);
            end
            tick(); tick(); tick();
        end
        rd(MB + 32'hC, 1'b0, 32'h0, 4'h0, 32'h1, 32'h1);

        dmem_r_en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            dmem_addr = pool[j];
            tick();
        end
        dmem_r_en = 1'b0;
        tick();
        check("pre-rst dvalid u2", 32'(d_valid[2]), 32'h1);
        check("pre-rst ddata u2", d_data[2], mget(pool[0]));
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async dvalid u%0d", i), 32'(d_valid[i]), 32'h0);
            check($sformatf("async ivalid u%0d", i), 32'(i_valid[i]), 32'h0);
            check($sformatf("async ddata u%0d", i), d_data[i], 32'h0);
            check($sformatf("async done u%0d", i), 32'(done[i]), 32'h0);
        end
        tick(); tick();
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            for (int i = 0; i < 3; i++)
                check($sformatf("no ghost dvalid u%0d k%0d", i, k), 32'(d_valid[i]), 32'h0);
        end
        for (int j = 0; j < 3; j++) rd(pool[j], 1'b0, 32'h0, 4'h0, mget(pool[j]), mget(pool[j]));
        rd(32'h40, 1'b0, 32'h0, 4'h0, 32'hAA22_CC44, 32'hAA22_CC44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/otter_tcm_sim.md
# otter_tcm_sim

Parametrised dual-port tightly-coupled memory for `otter_mcu` benches and FPGA builds. It serves an instruction read port and a byte-strobed data read/write port from one shared array, with configurable read latency and read-during-write policy. A small MMIO window drives the core's 32-bit `intrpt` vector and a simulation-exit register, so programs can raise their own interrupts and end a test.

## Interface
Parameters:
- `MEM_EXP`, 16: log2 of memory size in bytes. Word index is `addr[MEM_EXP-1:2]`.
- `RD_LATENCY`, 1: read latency in cycles. Legal range is 1..4.
- `WRITE_FIRST`, 0: read-during-write policy. 1 returns the new merged word; 0 returns the old word.
- `MMIO_BASE`, 32'h1100_0000: 16-byte-aligned base of the MMIO window.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `imem_addr`  in  32  instruction fetch address; read every cycle
- `imem_r_data`  out  32  fetched word
- `imem_r_valid`  out  1  `imem_r_data` corresponds to the address from `RD_LATENCY` cycles earlier
- `dmem_r_en`  in  1  data read request
- `dmem_w_en`  in  1  data write request
- `dmem_w_strb`  in  4  byte write enables
- `dmem_addr`  in  32  data address
- `dmem_w_data`  in  32  write data
- `dmem_r_data`  out  32  read data
- `dmem_r_valid`  out  1  delayed copy of `dmem_r_en`
- `ext_intr`  in  32  external interrupt sources; level, sticky into pending
- `intrpt`  out  32  pending-interrupt vector to the core
- `sim_done`  out  1  sticky; set by a write to EXIT
- `sim_code`  out  32  value written to EXIT

## Operation
- Memory array:
  - not reset; preloadable by `$readmemh` from the bench.
  - Addresses outside the MMIO window alias modulo 2^MEM_EXP.
- Data write:
  - When `dmem_w_en` is high, each byte lane with its strobe bit set is written.
  - `dmem_w_en` with all strobe bits 0 is a no-op.
- Simultaneous `dmem_r_en` and `dmem_w_en`:
  - Legal; addresses are the same by construction.
  - Read data follows `WRITE_FIRST`.
- `imem_addr` in the same word as a same-cycle data write also follows `WRITE_FIRST`.
- MMIO decode: `dmem_addr[31:4] == MMIO_BASE[31:4]`. MMIO accesses never touch the array.
- MMIO registers (offset: access, behaviour):
  - 0x0 SET, write: pending |= strobe-masked data.
  - 0x4 CLR, write: pending &= ~strobe-masked data.
  - 0x8 PEND, read: returns pending. Writes are ignored.
  - 0xC EXIT, write: `sim_code` ← strobe-merged data and `sim_done` ← 1. Reads return `sim_code`.
- MMIO reads of SET/CLR return 0. MMIO reads have the same latency as memory reads.
- Pending update, every cycle: pending_next = (pending | SETmask | ext_intr) & ~(CLRmask & ~ext_intr).
  - When a CLR and an asserted `ext_intr` hit the same bit, set wins.
- `intrpt` = pending register, output directly as a flop.
- Instruction fetch at an MMIO address returns 0.

## Timing
- Reset (while `rst` = 0):
  - `imem_r_data`, `dmem_r_data`, `intrpt`, `sim_code` = 0.
  - `imem_r_valid`, `dmem_r_valid`, `sim_done` = 0.
  - All read-pipeline stages cleared.
- Read data and valid appear exactly `RD_LATENCY` rising edges after the request edge.
  - Stage 1 is the array/MMIO read register; stages 2..N are delay registers.
- `imem_r_valid` rises `RD_LATENCY` cycles after reset release and then stays high.
- Back-to-back reads are accepted every cycle; there are no stalls and no backpressure.
- `dmem_r_data` holds its last value while `dmem_r_valid` = 0. Pipeline data is not zeroed.
- Writes commit at the request edge. A read of the same word issued on the next cycle sees the new data, regardless of `WRITE_FIRST`.
- MMIO SET/CLR/`ext_intr` effects are visible on `intrpt` one cycle after the edge.
- Reset asserted mid-operation:
  - All in-flight reads are discarded and valids drop immediately (asynchronous).
  - Array contents are retained.

## Structure
- Package `otter_mem_pkg`:
  - MMIO offset constants: `MMIO_SET`, `MMIO_CLR`, `MMIO_PEND`, `MMIO_EXIT`.
  - Helper function `strb_merge(old, new, strb)`.
- Sub-module `rd_pipe #(WIDTH, DEPTH)`: a valid+data delay line with async active-low clear. It is instantiated once per port with `DEPTH = RD_LATENCY-1`; depth 0 is a passthrough.
- Top level contains the array, the collision/forwarding mux, MMIO decode and the pending register.

## Test plan
- Each preload is checked at `RD_LATENCY` = 1 and at `RD_LATENCY` = 3.
- Partial write:
  - Stimulus: preload word 0x40 = 32'hAABBCCDD; write 32'h11223344 to 0x40 with strobe 4'b0101.
  - Response: the next read returns 32'hAA22CC44 with valid exactly `RD_LATENCY` cycles later.
- Collision policy:
  - Stimulus: same-cycle read and write of 32'hDEADBEEF to 0x80, strobe 4'hF, old value 0.
  - Response: returns 0 when `WRITE_FIRST` = 0 and 32'hDEADBEEF when `WRITE_FIRST` = 1. `imem_addr` = 0x80 in the same cycle returns the same value.
- Interrupts:
  - Step 1: SET 32'h0000_0005. Then `intrpt` = 5 one cycle later.
  - Step 2: CLR 32'h1 while `ext_intr[0]` = 1. Then `intrpt` stays 5.
  - Step 3: drop `ext_intr` and CLR again. Then `intrpt` = 4, and a PEND read returns 4.
- Exit:
  - Stimulus: write 32'h0000_0001 to MMIO_BASE+0xC.
  - Response: `sim_done` = 1 and `sim_code` = 1 next cycle; both stay sticky until reset.
- Reset mid-read:
  - Stimulus: issue 3 consecutive dmem reads at `RD_LATENCY` = 4, then pull `rst` low between edges.
  - Response: `dmem_r_valid` drops immediately, no valid pulse follows release, and array contents are unchanged.
